// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve sequencing, ball motion, paddle/wall collision
// and scoring.
//
// Ports:
//   clk, rst              - clock; synchronous active-high reset
//   game_tick             - one-clk pulse advancing game time
//   serve_req             - one-clk pulse requesting a serve or restart
//   p1_x/p1_y, p2_x/p2_y  - paddle top-left corners
//   ball_x/ball_y         - ball top-left corner (registered)
//   score_p1/score_p2     - points won, saturating at 15 (registered)
//   state                 - IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
//   point_pulse/point_p1  - one-clk point strobe and scorer flag (1 = player 1)
//   game_over             - high while in OVER
module pong_game_ctrl #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned PAD_W       = 30,
  parameter int unsigned PAD_H       = 200,
  parameter int unsigned BALL        = 8,
  parameter int unsigned STEP        = 2,
  parameter int unsigned SERVE_TICKS = 60,
  parameter int unsigned WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_tick,
  input  logic       serve_req,
  input  logic [9:0] p1_x,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_x,
  input  logic [9:0] p2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [2:0] state,
  output logic       point_pulse,
  output logic       point_p1,
  output logic       game_over
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPoint = 3'd3,
    StOver  = 3'd4
  } state_e;

  localparam int unsigned CntW    = $clog2(SERVE_TICKS + 1);
  localparam logic [9:0]  CenterX = 10'((SCREEN_W - BALL) / 2);
  localparam logic [9:0]  CenterY = 10'((SCREEN_H - BALL) / 2);
  localparam logic [10:0] ScrW    = 11'(SCREEN_W);
  localparam logic [10:0] ScrH    = 11'(SCREEN_H);
  localparam logic [10:0] PadW    = 11'(PAD_W);
  localparam logic [10:0] PadH    = 11'(PAD_H);
  localparam logic [10:0] BallSz  = 11'(BALL);
  localparam logic [10:0] Step    = 11'(STEP);
  localparam logic [3:0]  WinSc   = 4'(WIN_SCORE);

  state_e            state_q, state_d;
  logic [9:0]        ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic              dir_x_q, dir_x_d;  // 1 = right
  logic              dir_y_q, dir_y_d;  // 1 = down
  logic [3:0]        score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic              point_pulse_q, point_pulse_d, point_p1_q, point_p1_d;
  logic              game_over_q, game_over_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // 11-bit views so no sum below can wrap
  logic [10:0] bx, by, p1x, p1y, p2x, p2y;
  logic        hit_p1, hit_p2, miss_l, miss_r;

  assign bx  = {1'b0, ball_x_q};
  assign by  = {1'b0, ball_y_q};
  assign p1x = {1'b0, p1_x};
  assign p1y = {1'b0, p1_y};
  assign p2x = {1'b0, p2_x};
  assign p2y = {1'b0, p2_y};

  // bx - Step < face is rewritten as bx < face + Step to avoid underflow
  assign hit_p1 = !dir_x_q && (bx >= p1x + PadW) && (bx < p1x + PadW + Step) &&
                  (by + BallSz > p1y) && (by < p1y + PadH);
  assign hit_p2 = dir_x_q && (bx + BallSz <= p2x) && (bx + BallSz + Step > p2x) &&
                  (by + BallSz > p2y) && (by < p2y + PadH);
  assign miss_l = !dir_x_q && (bx <= Step);
  assign miss_r = dir_x_q && (bx + BallSz + Step >= ScrW);

  always_comb begin
    state_d       = state_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    score_p1_d    = score_p1_q;
    score_p2_d    = score_p2_q;
    point_pulse_d = 1'b0;
    point_p1_d    = point_p1_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      StIdle: begin
        ball_x_d = CenterX;
        ball_y_d = CenterY;
        if (serve_req) begin
          state_d = StServe;
          cnt_d   = '0;
        end
      end
      StServe: begin
        ball_x_d = CenterX;
        ball_y_d = CenterY;
        if (game_tick) begin
          if (cnt_q == CntW'(SERVE_TICKS - 1)) begin
            state_d = StPlay;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StPlay: begin
        if (game_tick) begin
          if (!dir_y_q && by <= Step) begin
            ball_y_d = '0;
            dir_y_d  = 1'b1;
          end else if (dir_y_q && by + BallSz + Step >= ScrH) begin
            ball_y_d = 10'(ScrH - BallSz);
            dir_y_d  = 1'b0;
          end else begin
            ball_y_d = dir_y_q ? 10'(by + Step) : 10'(by - Step);
          end

          if (hit_p1) begin
            ball_x_d = 10'(p1x + PadW);
            dir_x_d  = 1'b1;
          end else if (hit_p2) begin
            ball_x_d = 10'(p2x - BallSz);
            dir_x_d  = 1'b0;
          end else if (miss_l) begin
            state_d       = StPoint;
            point_pulse_d = 1'b1;
            point_p1_d    = 1'b0;
            score_p2_d    = (score_p2_q == 4'hF) ? score_p2_q : score_p2_q + 4'd1;
          end else if (miss_r) begin
            state_d       = StPoint;
            point_pulse_d = 1'b1;
            point_p1_d    = 1'b1;
            score_p1_d    = (score_p1_q == 4'hF) ? score_p1_q : score_p1_q + 4'd1;
          end else begin
            ball_x_d = dir_x_q ? 10'(bx + Step) : 10'(bx - Step);
          end
        end
      end
      StPoint: begin
        if ((point_p1_q ? score_p1_q : score_p2_q) == WinSc) begin
          state_d = StOver;
        end else begin
          state_d  = StServe;
          cnt_d    = '0;
          ball_x_d = CenterX;
          ball_y_d = CenterY;
          // Serve toward whoever conceded: player 2 sits on the right
          dir_x_d  = point_p1_q;
        end
      end
      StOver: begin
        if (serve_req) begin
          state_d    = StServe;
          cnt_d      = '0;
          score_p1_d = '0;
          score_p2_d = '0;
          ball_x_d   = CenterX;
          ball_y_d   = CenterY;
        end
      end
      default: state_d = StIdle;
    endcase

    game_over_d = (state_d == StOver);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ball_x_q      <= CenterX;
      ball_y_q      <= CenterY;
      dir_x_q       <= 1'b1;
      dir_y_q       <= 1'b1;
      score_p1_q    <= '0;
      score_p2_q    <= '0;
      point_pulse_q <= 1'b0;
      point_p1_q    <= 1'b0;
      game_over_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      score_p1_q    <= score_p1_d;
      score_p2_q    <= score_p2_d;
      point_pulse_q <= point_pulse_d;
      point_p1_q    <= point_p1_d;
      game_over_q   <= game_over_d;
      cnt_q         <= cnt_d;
    end
  end

  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign score_p1    = score_p1_q;
  assign score_p2    = score_p2_q;
  assign state       = state_q;
  assign point_pulse = point_pulse_q;
  assign point_p1    = point_p1_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a default instance plus a WIN_SCORE=1
// instance sharing the same stimulus.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       game_tick = 1'b0;
  logic       serve_req = 1'b0;
  logic [9:0] p1_x = 10'd0, p1_y = 10'd0, p2_x = 10'd600, p2_y = 10'd0;

  logic [9:0] ball_x, ball_y, w_ball_x, w_ball_y;
  logic [3:0] score_p1, score_p2, w_score_p1, w_score_p2;
  logic [2:0] state, w_state;
  logic       point_pulse, point_p1, game_over;
  logic       w_point_pulse, w_point_p1, w_game_over;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .game_tick  (game_tick),
    .serve_req  (serve_req),
    .p1_x       (p1_x),
    .p1_y       (p1_y),
    .p2_x       (p2_x),
    .p2_y       (p2_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .state      (state),
    .point_pulse(point_pulse),
    .point_p1   (point_p1),
    .game_over  (game_over)
  );

  pong_game_ctrl #(.WIN_SCORE(1)) dut_w1 (
    .clk        (clk),
    .rst        (rst),
    .game_tick  (game_tick),
    .serve_req  (serve_req),
    .p1_x       (p1_x),
    .p1_y       (p1_y),
    .p2_x       (p2_x),
    .p2_y       (p2_y),
    .ball_x     (w_ball_x),
    .ball_y     (w_ball_y),
    .score_p1   (w_score_p1),
    .score_p2   (w_score_p2),
    .state      (w_state),
    .point_pulse(w_point_pulse),
    .point_p1   (w_point_p1),
    .game_over  (w_game_over)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are stable 1 ns after the edge.
  task automatic cyc(input logic t, input logic s);
    game_tick = t;
    serve_req = s;
    @(posedge clk);
    #1;
    game_tick = 1'b0;
    serve_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_state", 32'(state), 32'd0);
    check("rst_bx", 32'(ball_x), 32'd316);
    check("rst_by", 32'(ball_y), 32'd236);
    check("rst_s1", 32'(score_p1), 32'd0);
    check("rst_s2", 32'(score_p2), 32'd0);
    check("rst_pulse", 32'(point_pulse), 32'd0);
    check("rst_pp1", 32'(point_p1), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);

    // game_tick ignored in IDLE
    cyc(1'b1, 1'b0);
    check("idle_tick_state", 32'(state), 32'd0);

    // Simultaneous tick+serve: serve wins, tick not counted
    cyc(1'b1, 1'b1);
    check("serve_state", 32'(state), 32'd1);
    ticks(59);
    check("serve59_state", 32'(state), 32'd1);
    check("serve59_bx", 32'(ball_x), 32'd316);
    ticks(1);
    check("serve60_state", 32'(state), 32'd2);
    check("serve60_bx", 32'(ball_x), 32'd316);

    // First PLAY tick; no motion without a tick; serve ignored in PLAY
    ticks(1);
    check("play1_bx", 32'(ball_x), 32'd318);
    check("play1_by", 32'(ball_y), 32'd238);
    cyc(1'b0, 1'b1);
    check("notick_bx", 32'(ball_x), 32'd318);
    check("notick_by", 32'(ball_y), 32'd238);
    check("play_serve_ign", 32'(state), 32'd2);

    // Bottom-wall bounce on the 118th tick
    ticks(116);
    check("play117_by", 32'(ball_y), 32'd470);
    ticks(1);
    check("bounce_by", 32'(ball_y), 32'd472);
    check("bounce_bx", 32'(ball_x), 32'd552);
    ticks(1);
    check("after_bounce_by", 32'(ball_y), 32'd470);

    // Right paddle hit on the 114th tick
    p2_x = 10'd550;
    p2_y = 10'd270;
    do_reset();
    cyc(1'b0, 1'b1);
    ticks(60);
    check("hit_play_state", 32'(state), 32'd2);
    ticks(113);
    check("hit113_bx", 32'(ball_x), 32'd542);
    ticks(1);
    check("hit_bx", 32'(ball_x), 32'd542);
    check("hit_by", 32'(ball_y), 32'd464);
    check("hit_state", 32'(state), 32'd2);
    ticks(1);
    check("after_hit_bx", 32'(ball_x), 32'd540);

    // Right edge miss on the 158th tick
    p2_x = 10'd550;
    p2_y = 10'd0;
    do_reset();
    cyc(1'b0, 1'b1);
    ticks(60);
    ticks(157);
    check("miss157_bx", 32'(ball_x), 32'd630);
    check("miss157_pulse", 32'(point_pulse), 32'd0);
    ticks(1);
    check("miss_pulse", 32'(point_pulse), 32'd1);
    check("miss_pp1", 32'(point_p1), 32'd1);
    check("miss_s1", 32'(score_p1), 32'd1);
    check("miss_s2", 32'(score_p2), 32'd0);
    check("miss_state", 32'(state), 32'd3);
    check("miss_bx", 32'(ball_x), 32'd630);
    check("miss_by", 32'(ball_y), 32'd392);
    check("w1_miss_state", 32'(w_state), 32'd3);
    cyc(1'b1, 1'b0);
    check("point_state", 32'(state), 32'd1);
    check("point_bx", 32'(ball_x), 32'd316);
    check("point_by", 32'(ball_y), 32'd236);
    check("point_pulse_off", 32'(point_pulse), 32'd0);
    check("point_s1", 32'(score_p1), 32'd1);
    check("w1_over_state", 32'(w_state), 32'd4);
    check("w1_over_flag", 32'(w_game_over), 32'd1);
    check("w1_over_s1", 32'(w_score_p1), 32'd1);

    // Re-serve goes right (dir_x) and keeps dir_y (up after the bounce)
    ticks(60);
    check("reserve_state", 32'(state), 32'd2);
    check("w1_over_hold", 32'(w_state), 32'd4);
    ticks(1);
    check("reserve_bx", 32'(ball_x), 32'd318);
    check("reserve_by", 32'(ball_y), 32'd234);

    // serve_req in OVER restarts the WIN_SCORE=1 instance
    cyc(1'b0, 1'b1);
    check("w1_restart_state", 32'(w_state), 32'd1);
    check("w1_restart_s1", 32'(w_score_p1), 32'd0);
    check("w1_restart_s2", 32'(w_score_p2), 32'd0);
    check("w1_restart_over", 32'(w_game_over), 32'd0);
    check("w1_restart_bx", 32'(w_ball_x), 32'd316);
    check("play_ign_serve", 32'(state), 32'd2);

    // Reset mid-PLAY with a tick pending
    rst = 1'b1;
    cyc(1'b1, 1'b0);
    rst = 1'b0;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_bx", 32'(ball_x), 32'd316);
    check("midrst_by", 32'(ball_y), 32'd236);
    check("midrst_s1", 32'(score_p1), 32'd0);
    check("midrst_pulse", 32'(point_pulse), 32'd0);
    cyc(1'b1, 1'b0);
    check("midrst_pulse2", 32'(point_pulse), 32'd0);
    check("midrst_state2", 32'(state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
